// File: rtl/spi_pattern_responder_pkg.sv
// Shared register map and CTRL bit positions for the SPI pattern responder.
package spi_pattern_responder_pkg;

  localparam int REG_W = 32;

  // Register offsets relative to ADDR_BASE
  localparam logic [5:0] CTRL_OFF  = 6'd0;
  localparam logic [5:0] RESP0_OFF = 6'd1;

  // CTRL/STAT bit positions
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_DONE_BIT = 1;
  localparam int CTRL_OVR_BIT  = 2;

  // Synchronizer lane indices
  localparam int SYNC_SCLK = 0;
  localparam int SYNC_MOSI = 1;
  localparam int SYNC_CS   = 2;
  localparam int NUM_SYNC  = 3;

  // CAPT block follows the RESP block, whose size depends on the frame width
  function automatic logic [5:0] capt0_off(input int width);
    return 6'(1 + width / REG_W);
  endfunction

endpackage

// File: rtl/spi_pattern_responder_sync.sv
// Two-flop synchronizer for one asynchronous pin, plus an edge register
// that turns level changes into single-cycle rise/fall pulses.
module sync_edge_det (
  input  logic OPB_CLK,
  input  logic OPB_RST,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  // sr[1:0] are the metastability stages, sr[2] holds the previous synced value
  logic [2:0] sr;

  // shift the pin through the synchronizer and edge stage
  always_ff @(posedge OPB_CLK) begin
    if (OPB_RST) sr <= '0;
    else         sr <= {sr[1:0], din};
  end

  assign sync = sr[1];
  assign rise =  sr[1] & ~sr[2];
  assign fall = ~sr[1] &  sr[2];

endmodule

// File: rtl/spi_pattern_responder.sv
// SPI device-side loopback target: captures MOSI frames into CAPT and shifts
// the programmed RESP pattern out on MISO, all sampled in the OPB_CLK domain.
module spi_pattern_responder
  import spi_pattern_responder_pkg::*;
#(
  parameter int         WIDTH     = 128,
  parameter logic [5:0] ADDR_BASE = 6'h0
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RST,
  input  logic [5:0]  OPB_ADDR,
  input  logic [31:0] OPB_DI,
  output logic [31:0] OPB_DO,
  input  logic        OPB_RE,
  input  logic        OPB_WE,
  input  logic        SCLK_IN,
  input  logic        MOSI_IN,
  input  logic        CS_IN,
  output logic        MISO_OUT,
  output logic        MISO_OE,
  output logic        FRAME_IRQ
);

  localparam int         NW        = WIDTH / REG_W;
  localparam logic [5:0] CAPT0_OFF = capt0_off(WIDTH);
  localparam logic [5:0] LAST_OFF  = CAPT0_OFF + 6'(NW) - 6'd1;
  localparam logic [7:0] WIDTH_CNT = 8'(WIDTH);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACTIVE = 1'b1;

  // ---- pin synchronizers ----
  logic [NUM_SYNC-1:0] pin_raw, pin_s, pin_rise, pin_fall;
  assign pin_raw = {CS_IN, MOSI_IN, SCLK_IN};

  for (genvar g = 0; g < NUM_SYNC; g++) begin : g_sync
    sync_edge_det u_sync (
      .OPB_CLK (OPB_CLK),
      .OPB_RST (OPB_RST),
      .din     (pin_raw[g]),
      .sync    (pin_s[g]),
      .rise    (pin_rise[g]),
      .fall    (pin_fall[g])
    );
  end

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;
  assign sclk_rise = pin_rise[SYNC_SCLK];
  assign sclk_fall = pin_fall[SYNC_SCLK];
  assign cs_rise   = pin_rise[SYNC_CS];
  assign cs_fall   = pin_fall[SYNC_CS];
  assign mosi_s    = pin_s[SYNC_MOSI];

  // Only the pulses of SCLK/CS and the level of MOSI are consumed
  logic unused_sync;
  assign unused_sync = ^{pin_s[SYNC_SCLK], pin_s[SYNC_CS],
                         pin_rise[SYNC_MOSI], pin_fall[SYNC_MOSI]};

  // ---- state ----
  logic [0:0]       state;
  logic             enable, done, overrun, irq;
  logic [WIDTH-1:0] resp, capt, shift_in, shift_out;
  logic [7:0]       bit_cnt, bit_cnt_last;

  // ---- OPB decode ----
  logic [5:0] off;
  logic       wr_ctrl, abort;
  assign off     = OPB_ADDR - ADDR_BASE;
  assign wr_ctrl = OPB_WE && (off == CTRL_OFF);
  // A CTRL write with enable=0 kills the frame in the same cycle it lands
  assign abort   = wr_ctrl && !OPB_DI[CTRL_EN_BIT];

  // CS rise outranks a coincident SCLK edge; an abort outranks everything
  logic active_ok, frame_start, frame_end, shift_rise, shift_fall;
  assign active_ok   = (state == S_ACTIVE) && enable && !abort;
  assign frame_start = (state == S_IDLE) && enable && cs_fall;
  assign frame_end   = active_ok && cs_rise;
  assign shift_rise  = active_ok && !cs_rise && sclk_rise;
  assign shift_fall  = active_ok && !cs_rise && sclk_fall;

  // Frame FSM and shift datapath
  always_ff @(posedge OPB_CLK) begin
    if (OPB_RST) begin
      state        <= S_IDLE;
      shift_in     <= '0;
      shift_out    <= '0;
      bit_cnt      <= '0;
      bit_cnt_last <= '0;
      capt         <= '0;
      irq          <= 1'b0;
    end else begin
      irq <= 1'b0;
      case (state)
        S_IDLE: begin
          if (frame_start) begin
            state     <= S_ACTIVE;
            shift_out <= resp;
            shift_in  <= '0;
            bit_cnt   <= '0;
          end
        end
        S_ACTIVE: begin
          if (!active_ok) begin
            state <= S_IDLE;
          end else if (frame_end) begin
            state        <= S_IDLE;
            capt         <= shift_in;
            bit_cnt_last <= bit_cnt;
            irq          <= 1'b1;
          end else begin
            if (shift_rise) begin
              shift_in <= {shift_in[WIDTH-2:0], mosi_s};
              if (bit_cnt != 8'hFF) bit_cnt <= bit_cnt + 8'd1;
            end
            if (shift_fall)
              shift_out <= {shift_out[WIDTH-2:0], shift_out[WIDTH-1]};
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // CTRL flags: software writes, with hardware set taking priority over clear
  always_ff @(posedge OPB_CLK) begin
    if (OPB_RST) begin
      enable  <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        enable <= OPB_DI[CTRL_EN_BIT];
        if (OPB_DI[CTRL_DONE_BIT]) done    <= 1'b0;
        if (OPB_DI[CTRL_OVR_BIT])  overrun <= 1'b0;
      end
      if (frame_end) done <= 1'b1;
      if (shift_rise && (bit_cnt == WIDTH_CNT)) overrun <= 1'b1;
    end
  end

  // RESP pattern words; a mid-frame write only shows up at the next CS fall
  always_ff @(posedge OPB_CLK) begin
    if (OPB_RST) begin
      resp <= '0;
    end else begin
      for (int i = 0; i < NW; i++)
        if (OPB_WE && (off == RESP0_OFF + 6'(i)))
          resp[REG_W*i +: REG_W] <= OPB_DI;
    end
  end

  // Combinational read mux over CTRL, RESP and CAPT
  logic [31:0] rd_data;
  logic        rd_hit;
  always_comb begin
    rd_data = '0;
    rd_hit  = (off <= LAST_OFF);
    if (off == CTRL_OFF)
      rd_data = {16'h0, bit_cnt_last, 5'h0, overrun, done, enable};
    for (int i = 0; i < NW; i++) begin
      if (off == RESP0_OFF + 6'(i)) rd_data = resp[REG_W*i +: REG_W];
      if (off == CAPT0_OFF + 6'(i)) rd_data = capt[REG_W*i +: REG_W];
    end
  end

  assign OPB_DO    = (OPB_RE && rd_hit) ? rd_data : 32'bz;
  assign MISO_OE   = (state == S_ACTIVE);
  assign MISO_OUT  = (state == S_ACTIVE) & shift_out[WIDTH-1];
  assign FRAME_IRQ = irq;

endmodule
